// File: rtl/mesh_noc_pkg.sv
// mesh_noc_pkg: shared XY-mesh packet geometry and pack/unpack helpers.
// Packet layout is {row, col, data} with row in the MSBs.
package mesh_noc_pkg;

    localparam int DATA_OFF = 0;

    function automatic int calc_row_w(int row_n);
        return $clog2(row_n);
    endfunction

    function automatic int calc_col_w(int col_m);
        return $clog2(col_m);
    endfunction

    function automatic int calc_packet_w(int data_w, int row_n, int col_m);
        return data_w + calc_row_w(row_n) + calc_col_w(col_m);
    endfunction

    function automatic int col_off(int data_w);
        return data_w;
    endfunction

    function automatic int row_off(int data_w, int col_w);
        return data_w + col_w;
    endfunction

    // Fields are passed zero-extended; the caller truncates to PACKET_W.
    function automatic logic [63:0] pack_pckt(int data_w, int col_w, logic [31:0] row,
                                              logic [31:0] col, logic [31:0] data);
        return ({32'b0, row} << row_off(data_w, col_w)) | ({32'b0, col} << col_off(data_w)) | {32'b0, data};
    endfunction

    function automatic logic [63:0] get_field(logic [63:0] pckt, int off, int w);
        return (pckt >> off) & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: synchronous FIFO with extra-MSB pointers; head reads as 0 when empty.
module ni_fifo #(
    parameter int W            = 8,
    parameter int FIFO_DEPTH_W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_W;

    logic [W-1:0]          mem [DEPTH];
    logic [FIFO_DEPTH_W:0] wr_ptr, rd_ptr;
    logic                  do_wr, do_rd;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[FIFO_DEPTH_W] != rd_ptr[FIFO_DEPTH_W]) &&
                     (wr_ptr[FIFO_DEPTH_W-1:0] == rd_ptr[FIFO_DEPTH_W-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[FIFO_DEPTH_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr[FIFO_DEPTH_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mesh_rsc_ni.sv
// mesh_rsc_ni: resource-side NI that packetises/injects TX words and checks/delivers RX packets.
// Define MESH_RSC_NI_STATS_EN to build the tx/rx/drop statistics counters.
module mesh_rsc_ni
    import mesh_noc_pkg::*;
#(
    parameter int ROW_N        = 3,
    parameter int COL_M        = 3,
    parameter int FIFO_DEPTH_W = 3,
    parameter int PCKT_DATA_W  = 8,
    parameter int NODE_ROW     = 0,
    parameter int NODE_COL     = 0,
    localparam int ROW_W       = calc_row_w(ROW_N),
    localparam int COL_W       = calc_col_w(COL_M),
    localparam int PACKET_W    = calc_packet_w(PCKT_DATA_W, ROW_N, COL_M)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [PCKT_DATA_W-1:0] tx_data_i,
    input  logic [ROW_W-1:0]       tx_row_i,
    input  logic [COL_W-1:0]       tx_col_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic [PACKET_W-1:0]    rsc_pckt_o,
    output logic                   rsc_wren_o,
    input  logic                   noc_full_i,
    input  logic                   noc_ovrflw_i,
    input  logic [PACKET_W-1:0]    noc_pckt_i,
    input  logic                   noc_wren_i,
    output logic                   rsc_full_o,
    output logic                   rsc_ovrflw_o,
    output logic [PCKT_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   err_o,
    output logic [15:0]            tx_cnt_o,
    output logic [15:0]            rx_cnt_o,
    output logic [15:0]            drop_cnt_o
);
    localparam int ROW_OFF = row_off(PCKT_DATA_W, COL_W);
    localparam int COL_OFF = col_off(PCKT_DATA_W);

    logic                   tx_full, tx_empty, rx_full, rx_empty;
    logic                   tx_push, tx_in_range, tx_oor;
    logic                   rx_match, rx_wr, rx_misroute, rx_ovf, rx_pop;
    logic [PACKET_W-1:0]    tx_pckt;
    logic [ROW_W-1:0]       rx_row;
    logic [COL_W-1:0]       rx_col;
    logic [PCKT_DATA_W-1:0] rx_payload;
    logic                   err_q, ovrflw_q;

    assign tx_ready_o  = !tx_full;
    assign tx_push     = tx_valid_i && tx_ready_o;
    assign tx_in_range = (32'(tx_row_i) < ROW_N) && (32'(tx_col_i) < COL_M);
    assign tx_oor      = tx_push && !tx_in_range;
    assign tx_pckt     = PACKET_W'(pack_pckt(PCKT_DATA_W, COL_W, 32'(tx_row_i), 32'(tx_col_i), 32'(tx_data_i)));
    assign rsc_wren_o  = !tx_empty && !noc_full_i;

    ni_fifo #(.W(PACKET_W), .FIFO_DEPTH_W(FIFO_DEPTH_W)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (tx_push && tx_in_range),
        .wr_data (tx_pckt),
        .rd_en   (rsc_wren_o),
        .rd_data (rsc_pckt_o),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign rx_row      = ROW_W'(get_field(64'(noc_pckt_i), ROW_OFF, ROW_W));
    assign rx_col      = COL_W'(get_field(64'(noc_pckt_i), COL_OFF, COL_W));
    assign rx_payload  = PCKT_DATA_W'(get_field(64'(noc_pckt_i), DATA_OFF, PCKT_DATA_W));
    assign rx_match    = (32'(rx_row) == NODE_ROW) && (32'(rx_col) == NODE_COL);
    assign rx_misroute = noc_wren_i && !rx_match;
    // Full is the registered state, so a write alongside a pop while full is still dropped.
    assign rx_ovf      = noc_wren_i && rx_match && rx_full;
    assign rx_wr       = noc_wren_i && rx_match && !rx_full;
    assign rx_valid_o  = !rx_empty;
    assign rx_pop      = rx_valid_o && rx_ready_i;
    assign rsc_full_o  = rx_full;

    ni_fifo #(.W(PCKT_DATA_W), .FIFO_DEPTH_W(FIFO_DEPTH_W)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (rx_wr),
        .wr_data (rx_payload),
        .rd_en   (rx_pop),
        .rd_data (rx_data_o),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q    <= 1'b0;
            ovrflw_q <= 1'b0;
        end else begin
            err_q    <= err_q || noc_ovrflw_i || tx_oor || rx_misroute || rx_ovf;
            ovrflw_q <= rx_ovf;
        end
    end

    assign err_o        = err_q;
    assign rsc_ovrflw_o = ovrflw_q;

`ifdef MESH_RSC_NI_STATS_EN
    logic [15:0] tx_cnt, rx_cnt, drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (rsc_wren_o) tx_cnt <= tx_cnt + 16'd1;
            if (rx_pop) rx_cnt <= rx_cnt + 16'd1;
            drop_cnt <= drop_cnt + {15'b0, tx_oor} + {15'b0, rx_misroute || rx_ovf};
        end
    end

    assign tx_cnt_o   = tx_cnt;
    assign rx_cnt_o   = rx_cnt;
    assign drop_cnt_o = drop_cnt;
`else
    assign tx_cnt_o   = '0;
    assign rx_cnt_o   = '0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mesh_rsc_ni.sv
// tb_mesh_rsc_ni: directed scoreboard bench for mesh_rsc_ni at node (1,2) of a 3x3 mesh.
module tb_mesh_rsc_ni;

`ifdef MESH_RSC_NI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [1:0]  tx_row = '0, tx_col = '0;
    logic        tx_valid = 1'b0, tx_ready;
    logic [11:0] rsc_pckt;
    logic        rsc_wren, noc_full = 1'b0, noc_ovrflw = 1'b0;
    logic [11:0] noc_pckt = '0;
    logic        noc_wren = 1'b0, rsc_full, rsc_ovrflw;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready = 1'b0, err;
    logic [15:0] tx_cnt, rx_cnt, drop_cnt;

    int          checks = 0, passed = 0, tx_seen = 0;
    logic [31:0] tx_exp[$], rx_exp[$];

    always #5 clk = ~clk;

    mesh_rsc_ni #(
        .ROW_N(3), .COL_M(3), .FIFO_DEPTH_W(3), .PCKT_DATA_W(8), .NODE_ROW(1), .NODE_COL(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .tx_data_i(tx_data), .tx_row_i(tx_row), .tx_col_i(tx_col),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rsc_pckt_o(rsc_pckt), .rsc_wren_o(rsc_wren),
        .noc_full_i(noc_full), .noc_ovrflw_i(noc_ovrflw),
        .noc_pckt_i(noc_pckt), .noc_wren_i(noc_wren),
        .rsc_full_o(rsc_full), .rsc_ovrflw_o(rsc_ovrflw),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .err_o(err), .tx_cnt_o(tx_cnt), .rx_cnt_o(rx_cnt), .drop_cnt_o(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input int row, input int col, input int data);
        return 32'((row << 10) | (col << 8) | (data & 8'hFF));
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        tick();
        rst_ni = 1'b1;
    endtask

    // Outputs are stable mid-cycle; a head seen here is consumed on the next rising edge.
    always @(negedge clk) begin
        if (rst_ni && rsc_wren) begin
            chk("tx_pckt", 32'(rsc_pckt), tx_exp.size() != 0 ? tx_exp.pop_front() : 32'hDEAD_BEEF);
            tx_seen++;
        end
        if (rst_ni && rx_valid && rx_ready)
            chk("rx_data", 32'(rx_data), rx_exp.size() != 0 ? rx_exp.pop_front() : 32'hDEAD_BEEF);
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        #3;
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_wren", 32'(rsc_wren), 0);
        chk("rst_pckt", 32'(rsc_pckt), 0);
        chk("rst_rsc_full", 32'(rsc_full), 0);
        chk("rst_ovrflw", 32'(rsc_ovrflw), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnts", {tx_cnt, drop_cnt}, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Single TX packet, one-cycle latency, no bypass.
        tx_data = 8'hA5; tx_row = 2'd2; tx_col = 2'd0; tx_valid = 1'b1;
        #1 chk("tx_same_cycle_wren", 32'(rsc_wren), 0);
        tx_exp.push_back(pk(2, 0, 8'hA5));
        tick();
        tx_valid = 1'b0;
        chk("tx_wren_k1", 32'(rsc_wren), 1);
        chk("tx_pckt_k1", 32'(rsc_pckt), 32'h8A5);
        tick();
        chk("tx_wren_k2", 32'(rsc_wren), 0);
        chk("tx_cnt", 32'(tx_cnt), STATS ? 1 : 0);

        // Fill TX under router backpressure, then drain back-to-back.
        noc_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 8'(8'h10 + i); tx_row = 2'(i % 3); tx_col = 2'((i + 1) % 3); tx_valid = 1'b1;
            #1 chk("tx_ready_fill", 32'(tx_ready), (i < 8) ? 1 : 0);
            if (i < 8) tx_exp.push_back(pk(i % 3, (i + 1) % 3, 8'h10 + i));
            tick();
        end
        tx_valid = 1'b0;
        chk("tx_full_no_wren", 32'(rsc_wren), 0);
        base = tx_seen;
        noc_full = 1'b0;
        #1 chk("tx_ready_pop_cycle", 32'(tx_ready), 0);
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain_wren", 32'(rsc_wren), 1);
            tick();
        end
        chk("tx_drain_done", 32'(rsc_wren), 0);
        chk("tx_drain_count", 32'(tx_seen - base), 8);

        // Single RX packet, then pop.
        noc_pckt = 12'h63C; noc_wren = 1'b1;
        rx_exp.push_back(32'h3C);
        tick();
        noc_wren = 1'b0;
        chk("rx_valid", 32'(rx_valid), 1);
        chk("rx_head", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_empty_valid", 32'(rx_valid), 0);
        chk("rx_empty_data", 32'(rx_data), 0);
        chk("rx_cnt", 32'(rx_cnt), STATS ? 1 : 0);
        chk("err_clean", 32'(err), 0);

        // RX overflow: 8 stored, 9th dropped.
        for (int i = 0; i < 8; i++) begin
            noc_pckt = 12'(pk(1, 2, 8'h50 + i)); noc_wren = 1'b1;
            rx_exp.push_back(32'h50 + i);
            tick();
        end
        chk("rx_full", 32'(rsc_full), 1);
        chk("rx_full_no_err", 32'(err), 0);
        noc_pckt = 12'(pk(1, 2, 8'hEE));
        tick();
        noc_wren = 1'b0;
        chk("rx_ovrflw_pulse", 32'(rsc_ovrflw), 1);
        chk("rx_ovf_err", 32'(err), 1);
        chk("rx_drop_cnt", 32'(drop_cnt), STATS ? 1 : 0);
        tick();
        chk("rx_ovrflw_end", 32'(rsc_ovrflw), 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("rx_drain_valid", 32'(rx_valid), 1);
            tick();
        end
        rx_ready = 1'b0;
        chk("rx_drained", 32'(rx_valid), 0);
        chk("rx_sb_empty", 32'(rx_exp.size()), 0);

        // Misrouted RX packet.
        do_reset();
        chk("err_after_rst", 32'(err), 0);
        noc_pckt = 12'h077; noc_wren = 1'b1;
        tick();
        noc_wren = 1'b0;
        chk("misroute_not_stored", 32'(rx_valid), 0);
        chk("misroute_err", 32'(err), 1);
        chk("misroute_drop_cnt", 32'(drop_cnt), STATS ? 1 : 0);

        // Out-of-range TX destination.
        do_reset();
        tx_data = 8'h11; tx_row = 2'd3; tx_col = 2'd0; tx_valid = 1'b1;
        #1 chk("oor_ready", 32'(tx_ready), 1);
        tick();
        tx_valid = 1'b0;
        chk("oor_no_wren", 32'(rsc_wren), 0);
        chk("oor_err", 32'(err), 1);
        tick();
        chk("oor_still_no_wren", 32'(rsc_wren), 0);

        // Reset with both FIFOs half full.
        do_reset();
        noc_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'(8'h30 + i); tx_row = 2'd0; tx_col = 2'd1; tx_valid = 1'b1;
            noc_pckt = 12'(pk(1, 2, 8'h70 + i)); noc_wren = 1'b1;
            tick();
        end
        tx_valid = 1'b0; noc_wren = 1'b0; noc_full = 1'b0;
        #1 chk("pre_rst_rx_valid", 32'(rx_valid), 1);
        chk("pre_rst_wren", 32'(rsc_wren), 1);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_wren", 32'(rsc_wren), 0);
        chk("async_rst_pckt", 32'(rsc_pckt), 0);
        chk("async_rst_rx_valid", 32'(rx_valid), 0);
        chk("async_rst_rx_data", 32'(rx_data), 0);
        chk("async_rst_tx_ready", 32'(tx_ready), 1);
        tx_exp.delete();
        rx_exp.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_rx_valid", 32'(rx_valid), 0);
        chk("post_rst_wren", 32'(rsc_wren), 0);
        chk("tx_sb_empty", 32'(tx_exp.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mesh_rsc_ni.md
# mesh_rsc_ni

Resource-side network interface for one node of the XY mesh NoC. It sits between a local resource (core or traffic generator) and that node's router resource port. It packetises resource words with a destination into NoC packets, buffers them, and injects them only while the router is not full. It also buffers, checks and delivers packets the router ejects to the resource.

## Interface
- ROW_N, 3, mesh rows (≥2)
- COL_M, 3, mesh columns (≥2)
- FIFO_DEPTH_W, 3, log2 depth of each TX/RX FIFO (depth 8)
- PCKT_DATA_W, 8, payload width
- NODE_ROW, 0, this node's row index
- NODE_COL, 0, this node's column index
- Derived: ROW_W=$clog2(ROW_N), COL_W=$clog2(COL_M), PACKET_W=PCKT_DATA_W+ROW_W+COL_W; packet = {row[ROW_W], col[COL_W], data[PCKT_DATA_W]}, row in MSBs

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- tx_data_i  in  PCKT_DATA_W  payload from resource
- tx_row_i  in  ROW_W  destination row
- tx_col_i  in  COL_W  destination column
- tx_valid_i  in  1  resource offers word
- tx_ready_o  out  1  TX FIFO not full
- rsc_pckt_o  out  PACKET_W  packet to router
- rsc_wren_o  out  1  router write strobe
- noc_full_i  in  1  router resource FIFO full
- noc_ovrflw_i  in  1  router overflow indication
- noc_pckt_i  in  PACKET_W  packet from router
- noc_wren_i  in  1  router write strobe
- rsc_full_o  out  1  RX FIFO full (backpressure to router)
- rsc_ovrflw_o  out  1  RX write dropped
- rx_data_o  out  PCKT_DATA_W  delivered payload
- rx_valid_o  out  1  RX FIFO not empty
- rx_ready_i  in  1  resource consumes head
- err_o  out  1  sticky error
- tx_cnt_o, rx_cnt_o, drop_cnt_o  out  16 each  statistics

## Operation
- TX push: tx_valid_i && tx_ready_o. The word and destination are packed and written to the TX FIFO.
- TX destination out of range (tx_row_i≥ROW_N or tx_col_i≥COL_M): the handshake completes, nothing is written, and err_o is set.
- TX drain: rsc_wren_o = !tx_empty && !noc_full_i (combinational); rsc_pckt_o = TX head. Head pops on the same edge. One packet per cycle maximum.
- RX write: on noc_wren_i, the packet destination field is compared with NODE_ROW/NODE_COL.
  - Mismatch: packet dropped, err_o set.
  - Match with RX FIFO not full: payload stored.
  - Match with RX FIFO full: packet dropped; rsc_ovrflw_o pulses for 1 cycle, on the cycle after the dropped write.
- rsc_full_o is derived from the registered count. A write in the same cycle as a pop while full is still dropped.
- RX pop: rx_valid_o && rx_ready_i. rx_data_o = head payload when non-empty, 0 when empty.
- err_o becomes sticky high when any of these occur: noc_ovrflw_i high, TX out-of-range, RX misroute, RX overflow. Cleared only by reset.
- FIFO pointers are FIFO_DEPTH_W+1 bits; full/empty come from the MSB compare. Pointers wrap naturally.

## Timing
- Reset values: tx_ready_o=1, rsc_wren_o=0, rsc_pckt_o=0 (FIFO empty), rsc_full_o=0, rsc_ovrflw_o=0, rx_valid_o=0, rx_data_o=0, err_o=0, all counters 0.
- TX latency: push at edge k → rsc_wren_o high in cycle k+1 if noc_full_i=0. No same-cycle bypass.
- RX latency: noc_wren_i at edge k → rx_valid_o high in cycle k+1.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen and the count is unchanged.
- TX full with a pop in the same cycle: tx_ready_o stays low that cycle; the push is not accepted.
- Reset mid-operation: both FIFOs are flushed and in-flight packets are lost. Outputs return to reset values asynchronously.

## Configuration
- MESH_RSC_NI_STATS_EN defined:
  - tx_cnt_o counts injected packets (rsc_wren_o).
  - rx_cnt_o counts delivered pops.
  - drop_cnt_o counts TX out-of-range, RX misroute and RX overflow events.
  - All three wrap at 16 bits.
- Undefined: counters are not built and all three outputs are tied to 0. err_o is unaffected.

## Structure
- Package mesh_noc_pkg holds:
  - the ROW_W/COL_W/PACKET_W computation functions;
  - the field offset constants;
  - the packet pack/unpack functions, shared with the router and mesh.
- One sub-module, ni_fifo: parameterised sync FIFO (width, FIFO_DEPTH_W, async active-low reset), instantiated for TX (PACKET_W) and RX (PCKT_DATA_W).

## Test plan
- NODE_ROW=1, NODE_COL=2; push data 0xA5 to (2,0) with noc_full_i=0 → one cycle later rsc_pckt_o={2'd2,2'd0,8'hA5}, rsc_wren_o high for 1 cycle, tx_cnt_o=1.
- Hold noc_full_i=1 and push 9 words → tx_ready_o drops after the 8th. Release full → 8 packets on consecutive cycles in order, no duplicates.
- noc_wren_i with {1,2,0x3C}, rx_ready_i=0 → rx_valid_o=1, rx_data_o=0x3C. Pop → rx_valid_o=0, rx_data_o=0.
- Fill RX with 8 matching packets, write a 9th → rsc_full_o=1, rsc_ovrflw_o pulses 1 cycle, err_o=1, drop_cnt_o=1, and the 8 stored payloads are intact.
- noc_wren_i with destination {0,0} → nothing stored, err_o=1. Push to tx_row_i=3 (ROW_N=3) → no rsc_wren_o, err_o=1.
- Assert rst_ni low with both FIFOs half full → all outputs at reset values immediately. After release, rx_valid_o=0 and rsc_wren_o=0.
